// File: rtl/dual_debounce_pkg.sv
// dual_debounce_pkg
//   Shared definitions for the dual-channel switch debouncer: default
//   parameter values, the per-channel counter width and the per-channel
//   FSM state type.
//   No ports (package only).
package dual_debounce_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W               = 8;

  // STABLE: output agrees with the synced input.
  // PENDING: synced input has differed from the output for a run of
  //          consecutive samples that is still being counted.
  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/dual_debounce_channel.sv
// debounce_channel
//   One debounce lane: a SYNC_STAGES-deep synchroniser on the raw input
//   followed by a STABLE/PENDING FSM and an 8-bit run counter. The clean
//   output only inverts once the synced input has disagreed with it for
//   DEBOUNCE_CYCLES consecutive rising edges.
//   Optional feature macro: DUAL_DEBOUNCE_EDGE_EN adds a registered
//   one-cycle pulse on every output change.
//
//   Ports:
//     clk        - rising-edge clock
//     rst_n      - asynchronous active-low reset
//     raw        - asynchronous bouncy input
//     level      - clean registered level
//     edge_pulse - one-cycle pulse when level changes (DUAL_DEBOUNCE_EDGE_EN only)
module debounce_channel
  import dual_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
`ifdef DUAL_DEBOUNCE_EDGE_EN
  output logic edge_pulse,
`endif
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   toggle;
  logic                   s;

  // Oldest flop of the synchroniser chain is the only value the FSM sees.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample in between is a bounce and restarts the run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    toggle  = 1'b0;
    case (state_q)
      STABLE: begin
        if (s != level_q) begin
          state_d = PENDING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PENDING: begin
        if (s == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          toggle  = 1'b1;
          level_d = ~level_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

`ifdef DUAL_DEBOUNCE_EDGE_EN
  logic edge_q, edge_d;

  // Registered so the pulse appears on the same edge the level flips.
  always_comb begin
    edge_d = toggle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign edge_pulse = edge_q;
`endif

endmodule

// File: rtl/dual_debounce.sv
// dual_debounce
//   Two independent debounce lanes (A and B) for bouncy asynchronous inputs
//   that feed a downstream AND stage. Both outputs come straight from flops.
//   Optional feature macro: DUAL_DEBOUNCE_EDGE_EN adds a_edge/b_edge pulses.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     a_raw  - bouncy input, channel A
//     b_raw  - bouncy input, channel B
//     a      - clean level, channel A
//     b      - clean level, channel B
//     a_edge - one-cycle pulse on change of a (DUAL_DEBOUNCE_EDGE_EN only)
//     b_edge - one-cycle pulse on change of b (DUAL_DEBOUNCE_EDGE_EN only)
module dual_debounce
  import dual_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
`ifdef DUAL_DEBOUNCE_EDGE_EN
  output logic a_edge,
  output logic b_edge,
`endif
  output logic a,
  output logic b
);

  // Refuse to build with parameters the counter or chain cannot honour.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("dual_debounce: SYNC_STAGES must be in 2..4");
  end
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_deb
    $error("dual_debounce: DEBOUNCE_CYCLES must be in 2..255");
  end

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (a_raw),
`ifdef DUAL_DEBOUNCE_EDGE_EN
    .edge_pulse (a_edge),
`endif
    .level      (a)
  );

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (b_raw),
`ifdef DUAL_DEBOUNCE_EDGE_EN
    .edge_pulse (b_edge),
`endif
    .level      (b)
  );

endmodule

// File: tb/tb_dual_debounce.sv
// tb_dual_debounce
//   Self-checking bench for dual_debounce with default parameters.
//   Directed scenarios use constant expectations; the random scenario uses a
//   run-length reference model (output flips after DEBOUNCE_CYCLES
//   consecutive disagreeing synced samples).
module tb_dual_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk;
  logic rst_n;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
`ifdef DUAL_DEBOUNCE_EDGE_EN
  logic a_edge;
  logic b_edge;
`endif

  int total;
  int bad;

  dual_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
`ifdef DUAL_DEBOUNCE_EDGE_EN
    .a_edge (a_edge),
    .b_edge (b_edge),
`endif
    .a      (a),
    .b      (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel, a SYNC-deep history of raw samples and a
  // count of consecutive edges where the delayed sample disagreed with out.
  logic m_hist [2][SYNC];
  logic m_out  [2];
  logic m_edge [2];
  int   m_run  [2];

  always @(posedge clk or negedge rst_n) begin
    logic raw_v [2];
    logic s;
    raw_v[0] = a_raw;
    raw_v[1] = b_raw;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        for (int k = 0; k < SYNC; k++) m_hist[ch][k] = 1'b0;
        m_out[ch]  = 1'b0;
        m_edge[ch] = 1'b0;
        m_run[ch]  = 0;
      end else begin
        s = m_hist[ch][0];
        for (int k = 0; k < SYNC - 1; k++) m_hist[ch][k] = m_hist[ch][k+1];
        m_hist[ch][SYNC-1] = raw_v[ch];
        m_edge[ch] = 1'b0;
        if (s != m_out[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == DEB) begin
            m_out[ch]  = ~m_out[ch];
            m_edge[ch] = 1'b1;
            m_run[ch]  = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
    end
  end

  // Inputs change only on the falling edge; observations are made there too.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (a !== 1'b0 || b !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: a=%b b=%b required a=0 b=0", a, b);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (a !== 1'b1 || b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_rise: a=%b b=%b required a=1 b=1", a, b);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (a !== 1'b0 || b !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async: a=%b b=%b required a=0 b=0", a, b);
    end
`ifdef DUAL_DEBOUNCE_EDGE_EN
    total++;
    if (a_edge !== 1'b0 || b_edge !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_edges: a_edge=%b b_edge=%b required 0 0", a_edge, b_edge);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
  endtask

  task automatic test_single_rise();
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (a !== (i >= 6) || b !== 1'b0) begin
        bad++;
        $display("[TB] FAIL single_rise edge %0d: a=%b b=%b required a=%b b=0", i, a, b, (i >= 6));
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    a_raw = 1'b1;
    @(negedge clk);
    a_raw = 1'b0;
    @(negedge clk);
    a_raw = 1'b1;
    @(negedge clk);
    a_raw = 1'b0;
    @(negedge clk);
    a_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (a !== (i >= 6)) begin
        bad++;
        $display("[TB] FAIL bounce edge %0d: a=%b required %b", i, a, (i >= 6));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if ((a & b) !== (i >= 6) || a !== b) begin
        bad++;
        $display("[TB] FAIL simultaneous edge %0d: a=%b b=%b required both %b", i, a, b, (i >= 6));
      end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    b_raw = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (b !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_during_reset: b=%b required 0", b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (b !== (i >= 6) || a !== 1'b0) begin
        bad++;
        $display("[TB] FAIL abort_release edge %0d: a=%b b=%b required a=0 b=%b", i, a, b, (i >= 6));
      end
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    a_raw = 1'b1;
    repeat (3) @(negedge clk);
    a_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (a !== 1'b0) begin
        bad++;
        $display("[TB] FAIL short_pulse cycle %0d: a=%b required 0", i, a);
      end
    end
  endtask

  // A pulse exactly DEBOUNCE_CYCLES wide is the shortest that gets through;
  // it rises 6 edges after the raw rise and falls 6 edges after the raw fall.
  task automatic test_pulse_boundary();
    logic exp_a;
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 4) a_raw = 1'b0;
      exp_a = (i >= 6) && (i < 10);
      total++;
      if (a !== exp_a) begin
        bad++;
        $display("[TB] FAIL pulse_boundary edge %0d: a=%b required %b", i, a, exp_a);
      end
`ifdef DUAL_DEBOUNCE_EDGE_EN
      total++;
      if (a_edge !== ((i == 6) || (i == 10))) begin
        bad++;
        $display("[TB] FAIL a_edge edge %0d: a_edge=%b required %b", i, a_edge, ((i == 6) || (i == 10)));
      end
`endif
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++;
      if (a !== m_out[0] || b !== m_out[1]) begin
        bad++;
        $display("[TB] FAIL random cycle %0d: a=%b b=%b required a=%b b=%b", i, a, b, m_out[0], m_out[1]);
      end
`ifdef DUAL_DEBOUNCE_EDGE_EN
      total++;
      if (a_edge !== m_edge[0] || b_edge !== m_edge[1]) begin
        bad++;
        $display("[TB] FAIL random_edge cycle %0d: a_edge=%b b_edge=%b required %b %b", i, a_edge, b_edge, m_edge[0], m_edge[1]);
      end
`endif
      if ($urandom_range(0, 5) == 0) a_raw = ~a_raw;
      if ($urandom_range(0, 5) == 0) b_raw = ~b_raw;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    test_reset();
    test_single_rise();
    test_bounce();
    test_simultaneous();
    test_reset_abort();
    test_short_pulse();
    test_pulse_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
